// File: rtl/tb_mmio_pkg.sv
// Shared definitions for the MMIO testbench controller: register map, exit FSM states,
// status layout and the bus request payload.
package tb_mmio_pkg;

    localparam int unsigned WINDOW_AW = 5;

    localparam logic [2:0] REG_EXIT   = 3'd0;
    localparam logic [2:0] REG_PRINT  = 3'd1;
    localparam logic [2:0] REG_CYC_LO = 3'd2;
    localparam logic [2:0] REG_CYC_HI = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

    localparam int unsigned STAT_ARMED   = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_FULL    = 2;
    localparam int unsigned STAT_TIMEOUT = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DRAIN,
        SLEEP,
        DONE
    } exit_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mmio_req_t;

    // Expand byte enables into a 32-bit data mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/tb_mmio_char_fifo.sv
// Synchronous FIFO for console characters; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module tb_mmio_char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only visible through level_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tb_mmio_ctrl.sv
// MMIO testbench controller: exit/status register, buffered console, 64-bit cycle counter.
// Defining TB_MMIO_TIMEOUT_EN adds a watchdog that forces DONE with TIMEOUT_CODE.
module tb_mmio_ctrl
    import tb_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [63:0] TIMEOUT_CYC = 64'd10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    input  logic        core_sleep_i,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    mmio_req_t        bus;
    logic [31:0]      wdata_m;
    logic [31:0]      off;
    logic             hit;
    logic [2:0]       reg_idx;
    logic             print_wr_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       fifo_head;
    logic             exit_wr;
    logic             lo_rd;
    logic [31:0]      rdata_c;
    logic             unused_bits;

    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [63:0]      cnt_q;
    logic [31:0]      hi_snap_q;
    exit_state_e      state_q, state_d;
    logic [31:0]      code_q, code_d;
    logic             timed_out_q, timed_out_d;
    logic             exit_valid_q, exit_valid_d;
    logic [31:0]      exit_code_q, exit_code_d;

    // Address decode relative to the window base; byte offset bits are ignored.
    assign bus     = mmio_req_t'{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
    assign wdata_m = bus.wdata & be_mask(bus.be);
    assign off     = bus.addr - BASE_ADDR;
    assign hit     = (off[31:WINDOW_AW] == '0);
    assign reg_idx = off[4:2];

`ifdef TB_MMIO_TIMEOUT_EN
    assign unused_bits = ^off[1:0];
`else
    assign unused_bits = ^{off[1:0], TIMEOUT_CYC};
`endif

    // A PRINT write is held off while the FIFO is full, judged on the pre-pop state.
    assign print_wr_req = req_i && bus.we && hit && (reg_idx == REG_PRINT);
    assign gnt_o        = req_i && !(print_wr_req && fifo_full);
    assign fifo_push    = print_wr_req && !fifo_full;
    assign fifo_pop     = char_valid_o && char_ready_i;
    assign exit_wr      = gnt_o && bus.we && hit && (reg_idx == REG_EXIT);
    assign lo_rd        = gnt_o && !bus.we && hit && (reg_idx == REG_CYC_LO);

    tb_mmio_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (wdata_m[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign char_valid_o = !fifo_empty;
    assign char_o       = fifo_head;

    always_comb begin
        rdata_c = '0;
        if (hit) begin
            case (reg_idx)
                REG_EXIT:   rdata_c = code_q;
                REG_PRINT:  rdata_c = 32'(fifo_level);
                REG_CYC_LO: rdata_c = cnt_q[31:0];
                REG_CYC_HI: rdata_c = hi_snap_q;
                REG_STATUS: rdata_c = {28'b0, timed_out_q, fifo_full, fifo_empty,
                                       (state_q != IDLE)};
                default:    rdata_c = '0;
            endcase
        end
    end

    // One response per grant, one cycle later; writes answer with zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            hi_snap_q <= '0;
        end else begin
            rvalid_q <= gnt_o;
            rdata_q  <= (gnt_o && !bus.we) ? rdata_c : '0;
            cnt_q    <= cnt_q + 64'd1;
            if (lo_rd) hi_snap_q <= cnt_q[63:32];
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            code_q       <= '0;
            timed_out_q  <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            timed_out_q  <= timed_out_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    // Last EXIT write wins until DONE, after which the code is frozen.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        timed_out_d = timed_out_q;
        if (exit_wr && state_q != DONE) code_d = wdata_m;
        case (state_q)
            IDLE:    if (exit_wr) state_d = ARMED;
            ARMED:   state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = SLEEP;
            SLEEP:   if (core_sleep_i) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
`ifdef TB_MMIO_TIMEOUT_EN
        // Enter DONE on the edge where the counter reaches TIMEOUT_CYC.
        if (state_q != DONE && cnt_q >= TIMEOUT_CYC - 64'd1) begin
            state_d     = DONE;
            code_d      = TIMEOUT_CODE;
            timed_out_d = 1'b1;
        end
`endif
    end

    always_comb begin
        exit_valid_d = (state_d == DONE);
        exit_code_d  = (state_d == DONE) ? code_d : '0;
    end

    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;

endmodule
